// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves memory-wait, mult/div, branch-flush and
// load-use hazards into PC/pipeline-register enables and bubbles.
module hazard_ctrl #(
    parameter int MD_LAT  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        ref_clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_memread,
    input  logic        ex_branch_taken,
    input  logic        md_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        exmem_clr,
    output logic        memwb_clr,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_MDBUSY = 1'b1
    } state_t;

    // The pulse cycle itself counts as the first stall cycle, hence the -2.
    localparam logic [3:0] MD_LOAD   = 4'(MD_LAT - 2);
    localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  md_cnt_r;
    logic [3:0]  md_cnt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_s;
    logic        mem_timeout_r;
    logic [15:0] stall_cycles_r;
    logic        mem_stall_s;
    logic        md_stall_s;
    logic        load_use_s;
    logic        timeout_hit_s;

    // Raw hazard conditions
    always_comb begin
        mem_stall_s = mem_req & ~mem_ready;
        md_stall_s  = (state_r == ST_MDBUSY) | md_start;
        load_use_s  = ex_memread & (ex_rt != 5'd0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

    // Prioritised control outputs; a branch under a stall is simply held off
    // until the stall clears because ex_branch_taken is re-evaluated each cycle.
    always_comb begin
        pc_we     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        memwb_clr = 1'b0;
        if (rst) begin
            pc_we     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
            memwb_clr = 1'b1;
        end else if (mem_stall_s) begin
            pc_we     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
        end else if (md_stall_s) begin
            pc_we     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_clr = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
        end else if (load_use_s) begin
            pc_we     = 1'b0;
            ifid_en   = 1'b0;
            idex_clr  = 1'b1;
        end else begin
            pc_we     = 1'b1;
        end
    end

    // Mult/div occupancy sequencer; runs independently of memory stalls
    always_comb begin
        state_s  = state_r;
        md_cnt_s = md_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (md_start) begin
                    state_s  = ST_MDBUSY;
                    md_cnt_s = MD_LOAD;
                end else begin
                    state_s  = ST_RUN;
                    md_cnt_s = md_cnt_r;
                end
            end
            ST_MDBUSY: begin
                if (md_cnt_r <= 4'd1) begin
                    state_s  = ST_RUN;
                    md_cnt_s = 4'd0;
                end else begin
                    state_s  = ST_MDBUSY;
                    md_cnt_s = md_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s  = ST_RUN;
                md_cnt_s = 4'd0;
            end
        endcase
    end

    // Consecutive memory-wait counter and timeout detection
    always_comb begin
        wait_cnt_s    = 8'd0;
        timeout_hit_s = 1'b0;
        if (mem_stall_s) begin
            if (wait_cnt_r < WAIT_MAX) begin
                wait_cnt_s = wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_s = wait_cnt_r;
            end
            timeout_hit_s = (wait_cnt_r >= WAIT_LAST);
        end else begin
            wait_cnt_s    = 8'd0;
            timeout_hit_s = 1'b0;
        end
    end

    // State, counters and sticky status registers
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_r        <= ST_RUN;
            md_cnt_r       <= 4'd0;
            wait_cnt_r     <= 8'd0;
            mem_timeout_r  <= 1'b0;
            stall_cycles_r <= 16'd0;
        end else begin
            state_r    <= state_s;
            md_cnt_r   <= md_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            if (timeout_hit_s) begin
                mem_timeout_r <= 1'b1;
            end
            if (!pc_we && (stall_cycles_r != 16'hFFFF)) begin
                stall_cycles_r <= stall_cycles_r + 16'd1;
            end
        end
    end

    assign mem_timeout  = mem_timeout_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int MD_LAT  = 4;
    localparam int TIMEOUT = 16;

    logic        ref_clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_memread, ex_branch_taken, md_start, mem_req, mem_ready;
    logic        pc_we, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_clr, idex_clr, exmem_clr, memwb_clr;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.MD_LAT(MD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .ref_clk(ref_clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .md_start(md_start), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 ref_clk = ~ref_clk;

    // Reference model: md occupancy as an absolute end cycle, wait streak as a
    // plain count, stall total as an integer.
    int   cyc    = 0;
    int   md_end = -1;
    int   streak = 0;
    int   stalls = 0;
    logic tmo    = 1'b0;
    logic model_valid = 1'b0;
    logic md_busy, lu_now;
    logic [8:0] exp_now, dut_ctrl;

    // Bits: {pc_we, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr, memwb_clr}
    function automatic logic [8:0] exp_ctrl(input logic r, input logic ms, input logic md,
                                             input logic br, input logic lu);
        if (r)       return 9'b0_0000_1111;
        else if (ms) return 9'b0_0001_0001;
        else if (md) return 9'b0_0011_0010;
        else if (br) return 9'b1_1111_1100;
        else if (lu) return 9'b0_0111_0100;
        else         return 9'b1_1111_0000;
    endfunction

    assign md_busy  = (cyc <= md_end);
    assign lu_now   = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign exp_now  = exp_ctrl(rst, mem_req && !mem_ready, md_start || md_busy, ex_branch_taken, lu_now);
    assign dut_ctrl = {pc_we, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_clr, idex_clr, exmem_clr, memwb_clr};

    always @(posedge ref_clk) begin
        if (rst) begin
            md_end      <= -1;
            streak      <= 0;
            stalls      <= 0;
            tmo         <= 1'b0;
            model_valid <= 1'b1;
        end else begin
            if (md_start && !md_busy) md_end <= cyc + MD_LAT - 2;
            if (mem_req && !mem_ready) begin
                streak <= streak + 1;
                if (streak + 1 >= TIMEOUT) tmo <= 1'b1;
            end else begin
                streak <= 0;
            end
            if (!exp_now[8] && stalls < 65535) stalls <= stalls + 1;
        end
        cyc <= cyc + 1;
    end

    initial begin
        forever begin
            @(negedge ref_clk);
            if (model_valid) begin
                checks++;
                if (dut_ctrl !== exp_now) begin
                    failures++;
                    $display("FAIL ctrl cyc=%0d: got %b expected %b", cyc, dut_ctrl, exp_now);
                end
                checks++;
                if (mem_timeout !== tmo) begin
                    failures++;
                    $display("FAIL mem_timeout cyc=%0d: got %b expected %b", cyc, mem_timeout, tmo);
                end
                checks++;
                if (stall_cycles !== 16'(stalls)) begin
                    failures++;
                    $display("FAIL stall_cycles cyc=%0d: got %0d expected %0d", cyc, stall_cycles, stalls);
                end
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0; md_start = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic nxt();
        @(posedge ref_clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge ref_clk); #3;
        lit("rst_pc_we", int'(pc_we), 0);
        lit("rst_clr", int'({ifid_clr, idex_clr, exmem_clr, memwb_clr}), 15);
        lit("rst_en", int'({ifid_en, idex_en, exmem_en, memwb_en}), 0);
        lit("rst_stall_cycles", int'(stall_cycles), 0);
        nxt(); rst = 1'b0; #2;
        lit("post_rst_pc_we", int'(pc_we), 1);
        lit("post_rst_en", int'({ifid_en, idex_en, exmem_en, memwb_en}), 15);

        // Load-use, then the r0 exemption
        nxt(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9; #2;
        lit("lu_pc_we", int'(pc_we), 0);
        lit("lu_ifid_en", int'(ifid_en), 0);
        lit("lu_idex_clr", int'(idex_clr), 1);
        nxt(); idle(); #2;
        lit("lu_stall_cycles", int'(stall_cycles), 1);
        nxt(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; #2;
        lit("lu_r0_pc_we", int'(pc_we), 1);
        lit("lu_r0_idex_clr", int'(idex_clr), 0);
        nxt(); idle(); #2;
        lit("lu_r0_stall_cycles", int'(stall_cycles), 1);

        // Mult/div: stall in N..N+2, release at N+3
        nxt(); md_start = 1'b1; #2;
        lit("md_n_pc_we", int'(pc_we), 0);
        lit("md_n_exmem_clr", int'(exmem_clr), 1);
        for (int k = 1; k <= 2; k++) begin
            nxt(); idle(); #2;
            lit("md_busy_pc_we", int'(pc_we), 0);
            lit("md_busy_exmem_clr", int'(exmem_clr), 1);
        end
        nxt(); #2;
        lit("md_rel_pc_we", int'(pc_we), 1);
        lit("md_rel_exmem_clr", int'(exmem_clr), 0);
        lit("md_stall_cycles", int'(stall_cycles), 4);

        // 20-cycle memory wait with timeout
        for (int i = 1; i <= 20; i++) begin
            nxt(); mem_req = 1'b1; mem_ready = 1'b0; #2;
            lit("mem_pc_we", int'(pc_we), 0);
            lit("mem_memwb_clr", int'(memwb_clr), 1);
            lit("mem_timeout_seq", int'(mem_timeout), int'(i >= 17));
        end
        nxt(); mem_ready = 1'b1; #2;
        lit("mem_done_pc_we", int'(pc_we), 1);
        lit("mem_done_timeout", int'(mem_timeout), 1);
        lit("mem_stall_cycles", int'(stall_cycles), 24);
        nxt(); idle(); #2;
        lit("timeout_sticky", int'(mem_timeout), 1);

        // Branch beats load-use; branch deferred across a 3-cycle mem stall
        nxt(); ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; #2;
        lit("br_lu_pc_we", int'(pc_we), 1);
        lit("br_lu_clr", int'({ifid_clr, idex_clr}), 3);
        for (int i = 1; i <= 3; i++) begin
            nxt(); idle(); ex_branch_taken = 1'b1; mem_req = 1'b1; #2;
            lit("br_mem_pc_we", int'(pc_we), 0);
            lit("br_mem_ifid_clr", int'(ifid_clr), 0);
        end
        nxt(); mem_req = 1'b0; #2;
        lit("br_late_pc_we", int'(pc_we), 1);
        lit("br_late_clr", int'({ifid_clr, idex_clr}), 3);

        // Reset during an md stall
        nxt(); idle(); md_start = 1'b1; #2;
        lit("md_rst_n_pc_we", int'(pc_we), 0);
        nxt(); idle(); rst = 1'b1; #2;
        lit("md_rst_clr", int'({ifid_clr, idex_clr, exmem_clr, memwb_clr}), 15);
        nxt(); rst = 1'b0; #2;
        lit("md_rst_pc_we", int'(pc_we), 1);
        lit("md_rst_stall_cycles", int'(stall_cycles), 0);
        lit("md_rst_timeout", int'(mem_timeout), 0);

        // Randomized traffic, alternating fast and slow memory phases
        for (int c = 0; c < 4000; c++) begin
            logic slow;
            nxt();
            slow            = ((c / 250) % 2) == 1;
            rst             = slow ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 99) < 2);
            mem_req         = slow ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
            mem_ready       = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            md_start        = ($urandom_range(0, 9) == 0);
            ex_branch_taken = ($urandom_range(0, 9) < 2);
            ex_memread      = ($urandom_range(0, 9) < 4);
            ex_rt           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
        end
        nxt(); idle(); rst = 1'b0;
        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
